// File: rtl/bandai2003_pkg.sv
// Shared constants and state encoding for the Bandai 2003 cartridge unlock host and cartridge model.
package bandai2003_pkg;

    localparam logic [7:0]  ADDR_ACK   = 8'h5A;
    localparam logic [7:0]  ADDR_NAK   = 8'hA5;
    localparam logic [7:0]  ADDR_NIL   = 8'h00;
    localparam logic [19:0] BS_DEFAULT = 20'h14503;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RSTP  = 3'd1,
        ACK   = 3'd2,
        NAK   = 3'd3,
        SYNC  = 3'd4,
        SHIFT = 3'd5,
        CHECK = 3'd6,
        FIN   = 3'd7
    } state_e;

    // Increment a 4-bit counter, holding at 15.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'hF) begin
            r = 4'hF;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bandai2003_bs_capture.sv
// Serial bitstream capture: shift register filled from the MSB end, bit counter, and match compare.
module bandai2003_bs_capture
    import bandai2003_pkg::*;
#(
    parameter int              BITS   = 20,
    parameter logic [BITS-1:0] EXPECT = BITS'(BS_DEFAULT)
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            clear_i,
    input  logic            shift_en_i,
    input  logic            si_i,
    output logic [BITS-1:0] rx_word_o,
    output logic            bit_last_o,
    output logic            match_o
);

    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

    logic [BITS-1:0] sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Next shift-register contents and bit position.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (shift_en_i) begin
            sr_d = {si_i, sr_q[BITS-1:1]};
            if (cnt_q == CW'(BITS - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            sr_d  = sr_q;
        end
    end

    // Capture state registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign rx_word_o  = sr_q;
    assign bit_last_o = shift_en_i && (cnt_q == CW'(BITS - 1));
    // Case equality so an X/Z bit captured from the cartridge never counts as a match.
    assign match_o    = (sr_q === EXPECT);

endmodule

// File: rtl/bandai2003_unlock_host.sv
// Bandai 2003 cartridge unlock host: reset pulse, 5Ah/A5h unlock, stream capture, compare and retry.
// Optional build macro SI_SYNC_EN adds a 2-flop SI synchronizer and a 2-cycle SYNC state.
module bandai2003_unlock_host
    import bandai2003_pkg::*;
#(
    parameter int              BITS    = 20,
    parameter logic [BITS-1:0] EXPECT  = BITS'(BS_DEFAULT),
    parameter int              RST_CYC = 4,
    parameter int              RETRIES = 3
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            START,
    input  logic            SI,
    output logic            CART_RSTn,
    output logic [7:0]      ADDR_O,
    output logic            BUSY,
    output logic            DONE,
    output logic            OK,
    output logic            CTRL1_B8,
    output logic [BITS-1:0] RX_WORD,
    output logic [3:0]      FAIL_CNT
);

    localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    state_e         state_q, state_d;
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic [4:0]     att_q, att_d;
    logic           ok_q, ok_d;
    logic           ctrl_q, ctrl_d;
    logic [3:0]     fail_q, fail_d;
    logic           cart_rstn_q, cart_rstn_d;
    logic [7:0]     addr_q, addr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           si_s;
    logic           rst_last_s;
    logic           clear_s;
    logic           shift_en_s;
    logic           bit_last_s;
    logic           match_s;
    logic           accept_s;

    assign accept_s   = (state_q == IDLE) && START;
    assign rst_last_s = (rst_cnt_q == RCW'(RST_CYC - 1));
    assign shift_en_s = (state_q == SHIFT);
    assign clear_s    = (state_d == RSTP) && (state_q != RSTP);

`ifdef SI_SYNC_EN
    logic si_meta_q, si_sync_q;
    logic sync_q, sync_d;

    // Two-flop synchronizer for the cartridge SO line.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            si_meta_q <= 1'b1;
            si_sync_q <= 1'b1;
        end else begin
            si_meta_q <= SI;
            si_sync_q <= si_meta_q;
        end
    end

    // SYNC dwell counter: two cycles to cover the synchronizer delay.
    always_comb begin
        if (state_q == SYNC) begin
            sync_d = ~sync_q;
        end else begin
            sync_d = 1'b0;
        end
    end

    // SYNC dwell register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign si_s = si_sync_q;
`else
    assign si_s = SI;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = START ? RSTP : IDLE;
            RSTP:  state_d = rst_last_s ? ACK : RSTP;
            ACK:   state_d = NAK;
`ifdef SI_SYNC_EN
            NAK:   state_d = SYNC;
            SYNC:  state_d = sync_q ? SHIFT : SYNC;
`else
            NAK:   state_d = SHIFT;
            SYNC:  state_d = SHIFT;
`endif
            SHIFT: state_d = bit_last_s ? CHECK : SHIFT;
            CHECK: begin
                if (match_s) begin
                    state_d = FIN;
                end else if (att_q < 5'(RETRIES)) begin
                    state_d = RSTP;
                end else begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset-pulse timer, attempt counter and result flags.
    always_comb begin
        ok_d   = ok_q;
        ctrl_d = ctrl_q;
        fail_d = fail_q;
        att_d  = att_q;
        if (state_q == RSTP) begin
            rst_cnt_d = rst_cnt_q + RCW'(1);
        end else begin
            rst_cnt_d = '0;
        end
        if (accept_s) begin
            ok_d   = 1'b0;
            fail_d = 4'd0;
            att_d  = 5'd0;
        end else if (state_q == CHECK) begin
            if (match_s) begin
                ok_d   = 1'b1;
                ctrl_d = 1'b1;
            end else begin
                fail_d = sat_inc4(fail_q);
                att_d  = (att_q == 5'd31) ? att_q : att_q + 5'd1;
            end
        end else begin
            ok_d   = ok_q;
        end
    end

    // Output decode from the next state so the registered outputs line up with state_q.
    always_comb begin
        cart_rstn_d = 1'b1;
        addr_d      = ADDR_NIL;
        case (state_d)
            RSTP:    cart_rstn_d = 1'b0;
            ACK:     addr_d      = ADDR_ACK;
            NAK:     addr_d      = ADDR_NAK;
            default: addr_d      = ADDR_NIL;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            rst_cnt_q   <= '0;
            att_q       <= 5'd0;
            ok_q        <= 1'b0;
            ctrl_q      <= 1'b0;
            fail_q      <= 4'd0;
            cart_rstn_q <= 1'b1;
            addr_q      <= ADDR_NIL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            att_q       <= att_d;
            ok_q        <= ok_d;
            ctrl_q      <= ctrl_d;
            fail_q      <= fail_d;
            cart_rstn_q <= cart_rstn_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    bandai2003_bs_capture #(
        .BITS   (BITS),
        .EXPECT (EXPECT)
    ) u_capture (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .clear_i    (clear_s),
        .shift_en_i (shift_en_s),
        .si_i       (si_s),
        .rx_word_o  (RX_WORD),
        .bit_last_o (bit_last_s),
        .match_o    (match_s)
    );

    assign CART_RSTn = cart_rstn_q;
    assign ADDR_O    = addr_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign OK        = ok_q;
    assign CTRL1_B8  = ctrl_q;
    assign FAIL_CNT  = fail_q;

endmodule

// File: tb/tb_bandai2003_unlock_host.sv
// Scoreboard bench for bandai2003_unlock_host with a behavioural cartridge model on SI.
module tb_bandai2003_unlock_host;

    localparam int          BITS    = 20;
    localparam logic [19:0] EXPECT  = 20'h14503;
    localparam int          RST_CYC = 4;
    localparam int          RETRIES = 3;
`ifdef SI_SYNC_EN
    localparam int          SYNC_CYC = 2;
`else
    localparam int          SYNC_CYC = 0;
`endif
    // One attempt: reset pulse, ACK, NAK, [SYNC], SHIFT window, CHECK.
    localparam int          ATT_LEN = RST_CYC + 2 + SYNC_CYC + BITS + 1;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        START;
    logic        SI;
    logic        CART_RSTn;
    logic [7:0]  ADDR_O;
    logic        BUSY, DONE, OK, CTRL1_B8;
    logic [19:0] RX_WORD;
    logic [3:0]  FAIL_CNT;

    bandai2003_unlock_host #(
        .BITS(BITS), .EXPECT(EXPECT), .RST_CYC(RST_CYC), .RETRIES(RETRIES)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .SI(SI),
        .CART_RSTn(CART_RSTn), .ADDR_O(ADDR_O), .BUSY(BUSY), .DONE(DONE),
        .OK(OK), .CTRL1_B8(CTRL1_B8), .RX_WORD(RX_WORD), .FAIL_CNT(FAIL_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- cartridge model ----------------
    logic [19:0] streams[$];
    logic [19:0] cart_sr  = 20'hFFFFF;
    int          load_idx = 0;

    function automatic logic [19:0] stream_at(input int i);
        if (streams.size() == 0) return 20'hFFFFF;
        if (i >= streams.size()) return streams[streams.size()-1];
        return streams[i];
    endfunction

    always @(posedge CLK) begin
        if (START && !BUSY) load_idx <= 0;
        else if (ADDR_O == 8'hA5) begin
            cart_sr  <= stream_at(load_idx);
            load_idx <= load_idx + 1;
        end else cart_sr <= {1'b1, cart_sr[19:1]};
    end

    assign SI = CART_RSTn ? cart_sr[0] : 1'bx;

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic        ok;
        logic        ctrl_before;
        logic        ctrl_after;
        logic [19:0] rx;
        logic [4:0]  fail;
        logic [4:0]  att;
        logic [15:0] lat;
    } exp_t;

    exp_t sb[$];
    logic ctrl_model = 1'b0;
    int   n_seq = 0;

    function automatic exp_t predict();
        exp_t e;
        int   misses = 0;
        int   att = RETRIES + 1;
        logic ok = 1'b0;
        for (int i = 0; i <= RETRIES; i++) begin
            if (stream_at(i) == EXPECT) begin
                ok  = 1'b1;
                att = i + 1;
                break;
            end
            misses++;
        end
        e.ok          = ok;
        e.ctrl_before = ctrl_model;
        e.ctrl_after  = ctrl_model | ok;
        e.rx          = stream_at(att - 1);
        e.fail        = 5'((misses > 15) ? 15 : misses);
        e.att         = 5'(att);
        e.lat         = 16'(att * ATT_LEN + 1);
        return e;
    endfunction

    // ---------------- monitor ----------------
    int         m_start, m_pulses, m_lowcyc, m_ack, m_nak, dones = 0;
    logic       prev_busy = 1'b0, prev_rstn = 1'b1;
    logic [7:0] seq[$];

    initial begin
        exp_t e;
        logic seq_ok;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                prev_busy = 1'b0;
                prev_rstn = 1'b1;
                seq.delete();
            end else begin
                if (BUSY && !prev_busy) begin
                    m_start = cyc; m_pulses = 0; m_lowcyc = 0; m_ack = 0; m_nak = 0;
                    seq.delete();
                    chk("ok_cleared_at_accept", 32'(OK), 32'd0);
                    if (sb.size() > 0) chk("ctrl_at_accept", 32'(CTRL1_B8), 32'(sb[0].ctrl_before));
                end
                if (BUSY) begin
                    if (!CART_RSTn) m_lowcyc++;
                    if (!CART_RSTn && prev_rstn) m_pulses++;
                    if (ADDR_O == 8'h5A) m_ack++;
                    if (ADDR_O == 8'hA5) m_nak++;
                    if (seq.size() == 0 || seq[seq.size()-1] != ADDR_O) seq.push_back(ADDR_O);
                end
                if (DONE) begin
                    dones++;
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("ok",        32'(OK),       32'(e.ok));
                        chk("ctrl1_b8",  32'(CTRL1_B8), 32'(e.ctrl_after));
                        chk("rx_word",   32'(RX_WORD),  32'(e.rx));
                        chk("fail_cnt",  32'(FAIL_CNT), 32'(e.fail));
                        chk("latency",   32'(cyc - m_start + 1), 32'(e.lat));
                        chk("rst_pulses",32'(m_pulses), 32'(e.att));
                        chk("rst_cycles",32'(m_lowcyc), 32'(e.att * RST_CYC));
                        chk("ack_cycles",32'(m_ack),    32'(e.att));
                        chk("nak_cycles",32'(m_nak),    32'(e.att));
                        seq_ok = (seq.size() == 1 + 3 * e.att) && (seq[0] == 8'h00);
                        for (int i = 0; seq_ok && i < e.att; i++) begin
                            if (seq[1+3*i] != 8'h5A || seq[2+3*i] != 8'hA5 || seq[3+3*i] != 8'h00)
                                seq_ok = 1'b0;
                        end
                        chk("addr_order", 32'(seq_ok), 32'd1);
                    end
                end
                prev_busy = BUSY;
                prev_rstn = CART_RSTn;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        @(posedge CLK); #1 START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
    endtask

    task automatic launch();
        exp_t e;
        e = predict();
        sb.push_back(e);
        ctrl_model = e.ctrl_after;
        n_seq++;
        pulse_start();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 3000) begin
            @(posedge CLK); #1;
            n++;
        end
        if (BUSY) chk("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(posedge CLK);
    endtask

    task automatic wait_nak();
        int n = 0;
        while (ADDR_O != 8'hA5 && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        if (ADDR_O != 8'hA5) chk("nak_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_seq(input bit stray);
        launch();
        if (stray) begin
            repeat ($urandom_range(0, 15)) @(posedge CLK);
            #1 START = 1'b1;
            @(posedge CLK); #1 START = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] bad;
        int          k, n;
        RSTn  = 1'b0;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_cart_rstn", 32'(CART_RSTn), 32'd1);
        chk("rst_addr",      32'(ADDR_O),    32'd0);
        chk("rst_busy",      32'(BUSY),      32'd0);
        chk("rst_done",      32'(DONE),      32'd0);
        chk("rst_ok",        32'(OK),        32'd0);
        chk("rst_ctrl",      32'(CTRL1_B8),  32'd0);
        chk("rst_rx",        32'(RX_WORD),   32'd0);
        chk("rst_fail",      32'(FAIL_CNT),  32'd0);
        @(negedge CLK); RSTn = 1'b1;
        repeat (2) @(posedge CLK);

        // Stuck all-ones cartridge: every attempt mismatches.
        streams.delete(); streams.push_back(20'hFFFFF);
        run_seq(1'b0);
        // Clean first-try unlock.
        streams.delete(); streams.push_back(EXPECT);
        run_seq(1'b0);
        // One bad stream then correct.
        streams.delete(); streams.push_back(20'h14502); streams.push_back(EXPECT);
        run_seq(1'b0);

        // START during SHIFT and during FIN must both be ignored.
        streams.delete(); streams.push_back(EXPECT);
        launch();
        wait_nak();
        repeat (3) @(posedge CLK);
        #1 START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        n = 0;
        while (!DONE && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("done_seen", 32'(DONE), 32'd1);
        START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        chk("fin_start_ignored", 32'(BUSY), 32'd0);
        repeat (3) @(posedge CLK);
        #1 chk("still_idle", 32'(BUSY), 32'd0);

        // Randomized sequences with a mix of bad streams before the good one.
        for (int s = 0; s < 20; s++) begin
            streams.delete();
            k = $urandom_range(0, 5);
            for (int j = 0; j < k; j++) begin
                bad = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : 20'($urandom);
                if (bad == EXPECT) bad = bad ^ 20'h00001;
                streams.push_back(bad);
            end
            streams.push_back(EXPECT);
            run_seq(1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of SHIFT.
        streams.delete(); streams.push_back(EXPECT);
        pulse_start();
        wait_nak();
        repeat (5) @(posedge CLK);
        #2 RSTn = 1'b0;
        #1;
        chk("mid_rst_cart_rstn", 32'(CART_RSTn), 32'd1);
        chk("mid_rst_addr",      32'(ADDR_O),    32'd0);
        chk("mid_rst_busy",      32'(BUSY),      32'd0);
        chk("mid_rst_rx",        32'(RX_WORD),   32'd0);
        chk("mid_rst_ctrl",      32'(CTRL1_B8),  32'd0);
        ctrl_model = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK); RSTn = 1'b1;
        repeat (2) @(posedge CLK);
        run_seq(1'b0);

        repeat (5) @(posedge CLK);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("done_count",       32'(dones),     32'(n_seq));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
